// File: rtl/chroma_key_auto_cal.sv
// Window-average backdrop calibration producing G_min / RG_max keying thresholds.
// Optional CK_CAL_CONTINUOUS_EN: level-sensitive start, recalibrates every frame while held.
module chroma_key_auto_cal #(
    parameter int WIN_X0         = 288,
    parameter int WIN_Y0         = 208,
    parameter int WIN_LOG2_W     = 6,
    parameter int WIN_LOG2_H     = 6,
    parameter int G_MARGIN       = 32,
    parameter int RG_MARGIN      = 16,
    parameter int DEF_G_MIN      = 100,
    parameter int DEF_RG_MAX     = 40,
    parameter int VS_ACTIVE_HIGH = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [23:0] rgb_data,
    output logic [7:0]  G_min,
    output logic [7:0]  RG_max,
    output logic        busy,
    output logic        valid,
    output logic        err
);
    localparam int S  = WIN_LOG2_W + WIN_LOG2_H;
    localparam int SW = 8 + S;
    localparam int CW = S + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << S) - 1);
    localparam logic [12:0] X_LO = 13'(WIN_X0);
    localparam logic [12:0] X_HI = 13'(WIN_X0 + (1 << WIN_LOG2_W));
    localparam logic [12:0] Y_LO = 13'(WIN_Y0);
    localparam logic [12:0] Y_HI = 13'(WIN_Y0 + (1 << WIN_LOG2_H));

    typedef enum logic [2:0] {IDLE, WAIT_FRAME, ACCUM, CALC0, CALC1} state_t;
    state_t state, state_nx;

    logic          vs_act, vs_d, frame_start;
    logic          de_d, de_fall;
    logic          start_acc;
    logic [11:0]   col, row;
    logic          in_win, sample, last_smp;
    logic [7:0]    pix_r, pix_g, pix_b, pix_m;
    logic [SW-1:0] sum_g, sum_m;
    logic [CW-1:0] smp_cnt;
    logic [7:0]    avg_g, avg_m;
    logic signed [9:0] g_lo, m_hi;
    logic [7:0]    g_clamp, m_clamp;
    logic          clr_acc, acc_en, abort;

    assign vs_act      = (VS_ACTIVE_HIGH != 0) ? i_vsync : ~i_vsync;
    assign frame_start = vs_act & ~vs_d;
    assign de_fall     = de_d & ~i_de;

`ifdef CK_CAL_CONTINUOUS_EN
    assign start_acc = start;
`else
    logic start_d;
    assign start_acc = start & ~start_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_d <= 1'b0;
        else        start_d <= start;
    end
`endif

    // vs_d resets high so a reset released mid-vsync does not fake a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b1;
            de_d <= 1'b0;
        end else begin
            vs_d <= vs_act;
            de_d <= i_de;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (i_de)         col <= col + 12'd1;
            else if (de_fall) col <= '0;
            if (frame_start)  row <= '0;
            else if (de_fall) row <= row + 12'd1;
        end
    end

    assign {pix_r, pix_g, pix_b} = rgb_data;
    assign pix_m    = (pix_r > pix_b) ? pix_r : pix_b;
    assign in_win   = ({1'b0, col} >= X_LO) && ({1'b0, col} < X_HI) &&
                      ({1'b0, row} >= Y_LO) && ({1'b0, row} < Y_HI);
    assign sample   = i_de & in_win;
    assign last_smp = (smp_cnt == LAST_CNT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start_acc) state_nx = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_nx = ACCUM;
            ACCUM: begin
                if (frame_start)            state_nx = IDLE;
                else if (sample && last_smp) state_nx = CALC0;
            end
            CALC0:      state_nx = CALC1;
            CALC1: begin
`ifdef CK_CAL_CONTINUOUS_EN
                state_nx = start ? WAIT_FRAME : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign clr_acc = (state_nx == WAIT_FRAME) && (state != WAIT_FRAME);
    assign acc_en  = (state == ACCUM) && sample && !frame_start;
    assign abort   = (state == ACCUM) && frame_start;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_g   <= '0;
            sum_m   <= '0;
            smp_cnt <= '0;
            avg_g   <= '0;
            avg_m   <= '0;
        end else begin
            if (clr_acc) begin
                sum_g   <= '0;
                sum_m   <= '0;
                smp_cnt <= '0;
            end else if (acc_en) begin
                sum_g   <= sum_g + {{S{1'b0}}, pix_g};
                sum_m   <= sum_m + {{S{1'b0}}, pix_m};
                smp_cnt <= smp_cnt + CW'(1);
            end
            if (state == CALC0) begin
                avg_g <= sum_g[SW-1:S];
                avg_m <= sum_m[SW-1:S];
            end
        end
    end

    // 10-bit signed headroom so neither clamp can wrap
    assign g_lo    = signed'({2'b00, avg_g}) - signed'(10'(G_MARGIN));
    assign m_hi    = signed'({2'b00, avg_m}) + signed'(10'(RG_MARGIN));
    assign g_clamp = g_lo[9] ? 8'd0 : g_lo[7:0];
    assign m_clamp = (m_hi[9:8] != 2'b00) ? 8'd255 : m_hi[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            G_min  <= 8'(DEF_G_MIN);
            RG_max <= 8'(DEF_RG_MAX);
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE && start_acc) err <= 1'b0;
            if (abort) err <= 1'b1;
            if (state == CALC1) begin
                if (avg_g <= avg_m) begin
                    err <= 1'b1;
                end else begin
                    G_min  <= g_clamp;
                    RG_max <= m_clamp;
                    valid  <= 1'b1;
                    err    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_chroma_key_auto_cal.sv
// Scoreboard bench for chroma_key_auto_cal on a reduced 32x20 video raster.
module tb_chroma_key_auto_cal;
    localparam int COLS = 32, ROWS = 20, HTOT = 40, VBL = 4;
    localparam int X0 = 8, Y0 = 4, LW = 3, LH = 2, NS = 32;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_ab = 1'b0;
    logic i_vsync = 1'b1, i_de = 1'b0;
    logic [23:0] rgb_data = '0;
    logic [7:0] G_min, RG_max, G_min_ab, RG_max_ab;
    logic busy, valid, err, busy_ab, valid_ab, err_ab;

    chroma_key_auto_cal #(.WIN_X0(X0), .WIN_Y0(Y0), .WIN_LOG2_W(LW), .WIN_LOG2_H(LH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .i_vsync(i_vsync), .i_de(i_de),
        .rgb_data(rgb_data), .G_min(G_min), .RG_max(RG_max), .busy(busy),
        .valid(valid), .err(err));

    // window rows 18..21 run past the last active line (19)
    chroma_key_auto_cal #(.WIN_X0(X0), .WIN_Y0(18), .WIN_LOG2_W(LW), .WIN_LOG2_H(LH)) dut_ab (
        .clk(clk), .rst_n(rst_n), .start(start_ab), .i_vsync(i_vsync), .i_de(i_de),
        .rgb_data(rgb_data), .G_min(G_min_ab), .RG_max(RG_max_ab), .busy(busy_ab),
        .valid(valid_ab), .err(err_ab));

    always #20 clk = ~clk;

    typedef struct { int g; int m; } exp_t;
    exp_t q[$];
    logic [7:0] sr[ROWS][COLS], sg[ROWS][COLS], sb[ROWS][COLS];
    int errors = 0, checks = 0, gen_line = 0, valid_ab_cnt = 0;
    int hold_g = 100, hold_m = 40;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // raster: vsync low on lines 0-1, blank lines 0-3, active lines 4-23
    initial begin
        forever begin
            for (int ln = 0; ln < ROWS + VBL; ln++) begin
                for (int px = 0; px < HTOT; px++) begin
                    @(posedge clk); #1;
                    gen_line = ln;
                    i_vsync  = (ln >= 2);
                    if (ln >= VBL && px < COLS) begin
                        i_de     = 1'b1;
                        rgb_data = {sr[ln-VBL][px], sg[ln-VBL][px], sb[ln-VBL][px]};
                    end else begin
                        i_de     = 1'b0;
                        rgb_data = '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            if (q.size() == 0) chk("valid_unexpected", 1, 0);
            else begin
                e = q.pop_front();
                chk("G_min", G_min, e.g);
                chk("RG_max", RG_max, e.m);
                chk("busy_at_valid", busy, 0);
                chk("err_at_valid", err, 0);
            end
        end
        if (valid_ab) valid_ab_cnt++;
    end

    task automatic fill(input int ir, input int ig, input int ib, input int o_r, input int o_g,
                        input int o_b, input int noise);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (r >= Y0 && r < Y0 + 4 && c >= X0 && c < X0 + 8) begin
                    sr[r][c] = 8'((ir + int'($urandom_range(0, noise)) > 255) ? 255 : ir + int'($urandom_range(0, noise)));
                    sg[r][c] = 8'((ig + int'($urandom_range(0, noise)) > 255) ? 255 : ig + int'($urandom_range(0, noise)));
                    sb[r][c] = 8'((ib + int'($urandom_range(0, noise)) > 255) ? 255 : ib + int'($urandom_range(0, noise)));
                end else begin
                    sr[r][c] = 8'(o_r); sg[r][c] = 8'(o_g); sb[r][c] = 8'(o_b);
                end
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        hold_g = 100; hold_m = 40;
    endtask

    task automatic wait_line(input int l);
        int n = 0;
        while (gen_line != l && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("wait_line_timeout", 1, 0);
    endtask

    task automatic run_cal(input bit extra);
        int sum_g = 0, sum_m = 0, ag, am, n = 0;
        bit exp_err;
        exp_t e;
        for (int r = Y0; r < Y0 + 4; r++)
            for (int c = X0; c < X0 + 8; c++) begin
                sum_g += sg[r][c];
                sum_m += (sr[r][c] > sb[r][c]) ? sr[r][c] : sb[r][c];
            end
        ag = sum_g / NS; am = sum_m / NS;
        exp_err = (ag <= am);
        if (!exp_err) begin
            e.g = (ag >= 32) ? ag - 32 : 0;
            e.m = (am + 16 > 255) ? 255 : am + 16;
            q.push_back(e);
            hold_g = e.g; hold_m = e.m;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (busy && n < 3000) begin
            @(negedge clk); n++;
            if (extra && (n == 20 || n == 200)) start = 1'b1;
            if (extra && (n == 22 || n == 202)) start = 1'b0;
        end
        if (busy) chk("busy_timeout", 1, 0);
        @(negedge clk);
        chk("err_final", err, int'(exp_err));
        chk("G_min_hold", G_min, hold_g);
        chk("RG_max_hold", RG_max, hold_m);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_G_min", G_min, 100);
        chk("rst_RG_max", RG_max, 40);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        fill(20, 200, 30, 20, 200, 30, 0);  run_cal(0);
        fill(10, 200, 10, 255, 0, 0, 0);    run_cal(0);
        fill(0, 20, 0, 0, 20, 0, 0);        run_cal(0);
        fill(250, 255, 0, 250, 255, 0, 0);  run_cal(0);
        do_reset();
        fill(200, 50, 0, 200, 50, 0, 0);    run_cal(0);
        fill(30, 180, 40, 0, 0, 0, 0);      run_cal(1);

        for (int k = 0; k < 8; k++) begin
            fill($urandom_range(0, 120), $urandom_range(60, 255), $urandom_range(0, 120),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 40));
            run_cal(k[0]);
        end

        // abort path: window never completes before the next frame start
        @(posedge clk); #1 start_ab = 1'b1;
        @(posedge clk); #1 start_ab = 1'b0;
        chk("ab_busy", busy_ab, 1);
        n = 0;
        while (busy_ab && n < 3000) begin @(negedge clk); n++; end
        if (busy_ab) chk("ab_timeout", 1, 0);
        chk("ab_err", err_ab, 1);
        chk("ab_G_min", G_min_ab, 100);
        chk("ab_RG_max", RG_max_ab, 40);
        chk("ab_valid_cnt", valid_ab_cnt, 0);

        // async reset in the middle of accumulation
        fill(20, 200, 30, 20, 200, 30, 0);
        wait_line(12);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_line(0);
        wait_line(6);
        chk("mid_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_G_min", G_min, 100);
        chk("mid_rst_RG_max", RG_max, 40);
        chk("mid_rst_busy", busy, 0);
        hold_g = 100; hold_m = 40;
        @(posedge clk); #1 rst_n = 1'b1;
        run_cal(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chroma_key_auto_cal.md
Name: chroma_key_auto_cal

Overview:
Measures the backdrop colour inside a fixed rectangular window of the live RGB888 stream from the video timing generator. From that measurement it produces the G_min / RG_max thresholds consumed by the chroma-key mixer, replacing manual VIO tuning. It sits in the 25 MHz pixel domain, in parallel with the mixer's data input, and drives the mixer's threshold inputs. Calibration is triggered, takes one frame, and its result is held until the next calibration.

Parameters:
WIN_X0, 288, window left column (active-pixel index)
WIN_Y0, 208, window top row (active-line index)
WIN_LOG2_W, 6, log2 of window width (64 px)
WIN_LOG2_H, 6, log2 of window height (64 lines)
G_MARGIN, 32, subtracted from mean G to form G_min
RG_MARGIN, 16, added to mean max(R,B) to form RG_max
DEF_G_MIN, 100, G_min reset value
DEF_RG_MAX, 40, RG_max reset value
VS_ACTIVE_HIGH, 0, vsync polarity (0 = active-low)

Ports:
clk  in  1  25 MHz pixel clock
rst_n  in  1  asynchronous active-low reset
start  in  1  calibration request; rising edge detected internally
i_vsync  in  1  vsync, same pipeline stage as rgb_data
i_de  in  1  data enable, same stage as rgb_data
rgb_data  in  24  {R,G,B} pixel
G_min  out  8  keying threshold: pixel keyed when G >= G_min
RG_max  out  8  keying threshold: pixel keyed when max(R,B) <= RG_max
busy  out  1  high from accepted start until result/abort
valid  out  1  one-cycle pulse when new thresholds are written
err  out  1  sticky status of last calibration (1 = rejected)

Behaviour:
- Reset values: G_min=DEF_G_MIN, RG_max=DEF_RG_MAX, busy=0, valid=0, err=0, FSM=IDLE, all accumulators 0.
- Frame start is the asserting edge of i_vsync, per VS_ACTIVE_HIGH.
- Position counters:
  - col increments on each i_de cycle and clears on the i_de falling edge.
  - row increments on each i_de falling edge and clears at frame start.
- In-window sample: i_de && col in [WIN_X0, WIN_X0+2^WIN_LOG2_W) && row in [WIN_Y0, WIN_Y0+2^WIN_LOG2_H).
- Sample count N = 2^(WIN_LOG2_W+WIN_LOG2_H).
- Accumulators:
  - sumG, width 8+WIN_LOG2_W+WIN_LOG2_H bits.
  - sumM, same width, accumulates max(R,B) per sample.
  - smp_cnt, counts accepted samples.
- FSM:
  - IDLE: on start rising edge → WAIT_FRAME, busy=1, err cleared, accumulators cleared.
  - WAIT_FRAME: on frame start → ACCUM.
  - ACCUM: accumulates each in-window sample. When smp_cnt reaches N (the Nth sample included) → CALC0. If a frame start arrives first (window outside active area) → IDLE, err=1, busy=0, outputs unchanged.
  - CALC0: avgG = sumG >> (W+H); avgM = sumM >> (W+H); both registered.
  - CALC1:
    - If avgG <= avgM: err=1, outputs unchanged.
    - Else: G_min = max(avgG - G_MARGIN, 0); RG_max = min(avgM + RG_MARGIN, 255); valid=1 for this cycle; err=0.
    - Either way → IDLE, busy=0.
- Arithmetic is unsigned. Clamps are computed in 10-bit signed intermediates; no wrap-around is permitted.
- Latency: results appear 2 cycles after the Nth window sample.
- start edges while busy=1 are ignored (no restart, no queueing).
- Outputs change only in CALC1 or on reset, so the mixer never sees a partial update.
- Async reset mid-operation returns to reset values immediately, including the thresholds.

Optional Feature:
Macro: CK_CAL_CONTINUOUS_EN.
- Defined: start is level-sensitive. While start=1, CALC1 returns to WAIT_FRAME instead of IDLE, recalibrating every frame; busy stays 1. Dropping start lets the current calibration finish, then the FSM goes to IDLE.
- Undefined: one calibration per start rising edge, as above.

Test Plan:
- Uniform frame R=20,G=200,B=30, defaults, pulse start → after one frame G_min=168, RG_max=46, single valid pulse, err=0, busy falls the same cycle.
- Window region G=200,R=B=10; everything outside it R=255,G=B=0 → G_min=168, RG_max=26 (outside pixels ignored).
- Clamp case: G=20,R=B=0 → G_min=0, RG_max=16. Separate run with R=250,G=255,B=0 → G_min=223, RG_max=255.
- Non-green scene R=200,G=50,B=0 → err=1, no valid pulse, G_min/RG_max keep their prior values (100/40 from reset).
- WIN_Y0=470 (window extends past line 479) → abort at next frame start, err=1, busy=0, outputs unchanged. Also: start pulses during busy → exactly one valid.
- rst_n low during ACCUM → G_min=100, RG_max=40, busy=0 immediately. A subsequent start yields a correct full calibration.
